// File: rtl/mem_check.sv
// Read-back checker for the S working memory: on start, sweeps all DEPTH
// addresses and compares each read word against (address ^ XOR_PAT).
module mem_check #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [7:0]  XOR_PAT    = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       state_start,
    input  logic [7:0] q,
    output logic       check_mem_handler,
    output logic [7:0] address,
    output logic [1:0] memory_sel,
    output logic       wen,
    output logic       finish,
    output logic       pass,
    output logic [8:0] fail_count,
    output logic [7:0] first_fail_addr
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_e;

    localparam logic [8:0] ADDR_LAST  = 9'(DEPTH - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(RD_LATENCY - 1);

    state_e     state_q, state_d;
    logic [8:0] addr_q, addr_d;
    logic [2:0] drain_q, drain_d;
    logic       handler_q, handler_d;
    logic       finish_q, finish_d;
    logic       pass_q, pass_d;
    logic [8:0] fail_cnt_q, fail_cnt_d;
    logic [7:0] first_fail_q, first_fail_d;

    logic [RD_LATENCY-1:0] vld_q;
    logic [7:0]            apipe_q [RD_LATENCY];
    logic                  mismatch;

    // Valid bit and issued address travel together so each q lines up with its address.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= (state_q == READ);
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        apipe_q[0] <= addr_q[7:0];
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            apipe_q[i] <= apipe_q[i-1];
        end
    end

    assign mismatch = vld_q[RD_LATENCY-1] &&
                      (q != (apipe_q[RD_LATENCY-1] ^ XOR_PAT));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        drain_d      = drain_q;
        handler_d    = handler_q;
        finish_d     = 1'b0;
        pass_d       = pass_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;

        case (state_q)
            IDLE: begin
                if (state_start) begin
                    state_d      = READ;
                    handler_d    = 1'b1;
                    addr_d       = '0;
                    fail_cnt_d   = '0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                end
            end
            READ: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 9'd1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                finish_d  = 1'b1;
                handler_d = 1'b0;
                pass_d    = (fail_cnt_q == 9'd0);
            end
            default: state_d = IDLE;
        endcase

        // Compares only land in READ/DRAIN, so this never collides with the start clear.
        if (mismatch) begin
            fail_cnt_d = fail_cnt_q + 9'd1;
            if (fail_cnt_q == 9'd0) begin
                first_fail_d = apipe_q[RD_LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            drain_q      <= '0;
            handler_q    <= 1'b0;
            finish_q     <= 1'b0;
            pass_q       <= 1'b0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            drain_q      <= drain_d;
            handler_q    <= handler_d;
            finish_q     <= finish_d;
            pass_q       <= pass_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign check_mem_handler = handler_q;
    assign address           = addr_q[7:0];
    assign memory_sel        = 2'b01;
    assign wen               = 1'b0;
    assign finish            = finish_q;
    assign pass              = pass_q;
    assign fail_count        = fail_cnt_q;
    assign first_fail_addr   = first_fail_q;

endmodule

// File: tb/tb_mem_check.sv
// Directed bench for mem_check: a RAM model feeds two instances (read latency 1
// and 3); expected pass results are queued at start and compared at finish.
module tb_mem_check;

    logic       clk;
    logic       reset;
    logic       start1, start3;
    logic [7:0] q1, q3;
    logic       hnd1, hnd3;
    logic [7:0] addr1, addr3;
    logic [1:0] msel1, msel3;
    logic       wen1, wen3;
    logic       fin1, fin3;
    logic       pass1, pass3;
    logic [8:0] fc1, fc3;
    logic [7:0] ffa1, ffa3;

    logic [7:0] mem [256];
    logic [7:0] p0, p1;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        string      tag;
        int         cycles;
        logic       pass;
        logic [8:0] fc;
        logic [7:0] ffa;
    } exp_t;
    exp_t sb[$];

    int fin_cnt1 = 0;
    int fin_cnt3 = 0;
    int prev_addr1 = -1;
    bit nonmono = 1'b0;
    bit wen_seen = 1'b0;
    bit msel_bad = 1'b0;

    mem_check #(.DEPTH(256), .RD_LATENCY(1), .XOR_PAT(8'h00)) dut (
        .clk(clk), .reset(reset), .state_start(start1), .q(q1),
        .check_mem_handler(hnd1), .address(addr1), .memory_sel(msel1), .wen(wen1),
        .finish(fin1), .pass(pass1), .fail_count(fc1), .first_fail_addr(ffa1)
    );

    mem_check #(.DEPTH(256), .RD_LATENCY(3), .XOR_PAT(8'h00)) dut3 (
        .clk(clk), .reset(reset), .state_start(start3), .q(q3),
        .check_mem_handler(hnd3), .address(addr3), .memory_sel(msel3), .wen(wen3),
        .finish(fin3), .pass(pass3), .fail_count(fc3), .first_fail_addr(ffa3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 1-cycle read for dut, 3-cycle read for dut3.
    always @(posedge clk) begin
        q1 <= mem[addr1];
        p0 <= mem[addr3];
        p1 <= p0;
        q3 <= p1;
    end

    always @(negedge clk) begin
        if (wen1 || wen3) wen_seen = 1'b1;
        if (msel1 != 2'b01 || msel3 != 2'b01) msel_bad = 1'b1;
        if (fin1) fin_cnt1++;
        if (fin3) fin_cnt3++;
        if (hnd1) begin
            if (prev_addr1 >= 0 && int'(addr1) < prev_addr1) nonmono = 1'b1;
            prev_addr1 = int'(addr1);
        end else begin
            prev_addr1 = -1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic fin_sel(input int lat);
        return (lat == 3) ? fin3 : fin1;
    endfunction

    task automatic push_expected(input string tag, input int lat);
        exp_t e;
        int   cnt = 0;
        int   first = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] != 8'(i)) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
        e.tag    = tag;
        e.cycles = 1 + 256 + lat;
        e.pass   = (cnt == 0);
        e.fc     = 9'(cnt);
        e.ffa    = 8'(first);
        sb.push_back(e);
    endtask

    task automatic run_pass(input string tag, input int lat, input bit double_start);
        exp_t e;
        int   cycles = 0;
        int   f0;
        push_expected(tag, lat);
        f0 = (lat == 3) ? fin_cnt3 : fin_cnt1;
        @(negedge clk);
        if (lat == 3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        while (cycles < 400 && !fin_sel(lat)) begin
            @(negedge clk);
            cycles++;
            if (double_start) start1 = (cycles == 50);
            if (cycles == 10) check({tag, " busy"}, (lat == 3) ? hnd3 : hnd1, 1'b1);
        end
        start1 = 1'b0;
        e = sb.pop_front();
        check({e.tag, " finish"}, fin_sel(lat), 1'b1);
        check({e.tag, " cycles"}, cycles, e.cycles);
        check({e.tag, " pass"}, (lat == 3) ? pass3 : pass1, e.pass);
        check({e.tag, " fail_count"}, (lat == 3) ? fc3 : fc1, e.fc);
        check({e.tag, " first_fail"}, (lat == 3) ? ffa3 : ffa1, e.ffa);
        check({e.tag, " released"}, (lat == 3) ? hnd3 : hnd1, 1'b0);
        @(negedge clk);
        check({e.tag, " finish width"}, fin_sel(lat), 1'b0);
        check({e.tag, " pass hold"}, (lat == 3) ? pass3 : pass1, e.pass);
        repeat (5) @(negedge clk);
        check({e.tag, " finish count"}, ((lat == 3) ? fin_cnt3 : fin_cnt1) - f0, 1);
    endtask

    initial begin
        int cycles;
        int f0;

        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        check("rst handler", hnd1, 1'b0);
        check("rst address", addr1, 8'h00);
        check("rst finish", fin1, 1'b0);
        check("rst pass", pass1, 1'b0);
        check("rst fail_count", fc1, 9'd0);
        check("rst first_fail", ffa1, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        run_pass("identity", 1, 1'b0);

        mem[8'h10] = 8'hAA;
        mem[8'hFF] = 8'h00;
        run_pass("two_bad", 1, 1'b0);

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        run_pass("all_zero", 1, 1'b0);

        // Reset mid-pass at address 0x80 with failures already counted.
        f0 = fin_cnt1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cycles = 0;
        while (cycles < 400 && addr1 != 8'h80) begin
            @(negedge clk);
            cycles++;
        end
        check("midrst reached", addr1, 8'h80);
        reset = 1'b1;
        @(negedge clk);
        check("midrst handler", hnd1, 1'b0);
        check("midrst address", addr1, 8'h00);
        check("midrst finish", fin1, 1'b0);
        check("midrst pass", pass1, 1'b0);
        check("midrst fail_count", fc1, 9'd0);
        check("midrst first_fail", ffa1, 8'h00);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        check("midrst no finish", fin_cnt1 - f0, 0);

        // Start coincident with reset is dropped.
        reset  = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wins handler", hnd1, 1'b0);
        check("rst_wins address", addr1, 8'h00);

        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        run_pass("after_reset", 1, 1'b0);
        run_pass("double_start", 1, 1'b1);
        check("double_start monotonic", nonmono, 1'b0);

        mem[8'h3C] = 8'h3D;
        run_pass("lat3_one_bad", 3, 1'b0);
        mem[8'h3C] = 8'h3C;
        run_pass("lat3_identity", 3, 1'b0);

        check("wen never high", wen_seen, 1'b0);
        check("memory_sel const", msel_bad, 1'b0);
        check("scoreboard empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
